// File: rtl/csa_seq_mult_if.sv
// Request/result bundle between the point-arithmetic controller and csa_seq_mult.
interface csa_seq_mult_if #(
  parameter int unsigned WID = 32
) ();
  logic               start;
  logic               clr;
  logic [WID-1:0]     a;
  logic [WID-1:0]     b;
  logic               busy;
  logic               done;
  logic [2*WID-1:0]   p;

  modport master (
    output start, clr, a, b,
    input  busy, done, p
  );

  modport slave (
    input  start, clr, a, b,
    output busy, done, p
  );
endinterface

// File: rtl/csa_seq_mult.sv
// Sequential radix-2 multiplier: one partial product per cycle kept in carry-save
// form, resolved by a single carry-propagate add before the result is handed off.
module csa_seq_mult_csa #(
  parameter int unsigned W = 64
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic [W-1:0] z,
  output logic [W-1:0] sum,
  output logic [W-1:0] carry_sh
);
  // Carry is emitted already shifted left by one; its top bit would fall off the product.
  always_comb begin
    sum      = x ^ y ^ z;
    carry_sh = {(x[W-2:0] & y[W-2:0]) | (x[W-2:0] & z[W-2:0]) | (y[W-2:0] & z[W-2:0]), 1'b0};
  end
endmodule

module csa_seq_mult #(
  parameter int unsigned WID = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  csa_seq_mult_if.slave   bus
);
  localparam int unsigned PW = 2 * WID;
  localparam int unsigned CW = (WID > 2) ? $clog2(WID) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WID - 1);

  typedef enum logic [1:0] {IDLE, ACC, RESOLVE} state_t;

  state_t          state;
  logic [PW-1:0]   s_vec;
  logic [PW-1:0]   c_vec;
  logic [PW-1:0]   ma;
  logic [WID-1:0]  mb;
  logic [CW-1:0]   cnt;
  logic [PW-1:0]   pp;
  logic [PW-1:0]   e_vec;
  logic [PW-1:0]   d_sh;
  logic            busy_r;
  logic            done_r;
  logic [PW-1:0]   p_r;

  always_comb begin
    pp = mb[0] ? ma : '0;
  end

  csa_seq_mult_csa #(.W(PW)) u_csa (
    .x        (s_vec),
    .y        (c_vec),
    .z        (pp),
    .sum      (e_vec),
    .carry_sh (d_sh)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      s_vec  <= '0;
      c_vec  <= '0;
      ma     <= '0;
      mb     <= '0;
      cnt    <= '0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      p_r    <= '0;
    end else begin
      done_r <= 1'b0;
      if (bus.clr) begin
        state  <= IDLE;
        busy_r <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (bus.start) begin
              ma     <= {{WID{1'b0}}, bus.a};
              mb     <= bus.b;
              s_vec  <= '0;
              c_vec  <= '0;
              cnt    <= '0;
              busy_r <= 1'b1;
              state  <= ACC;
            end
          end
          ACC: begin
            s_vec <= e_vec;
            c_vec <= d_sh;
            ma    <= ma << 1;
            mb    <= mb >> 1;
            cnt   <= cnt + 1'b1;
            // Stop once no multiplier bits remain after this one.
            if ((mb[WID-1:1] == '0) || (cnt == CNT_LAST)) begin
              state <= RESOLVE;
            end
          end
          RESOLVE: begin
            p_r    <= s_vec + c_vec;
            done_r <= 1'b1;
            busy_r <= 1'b0;
            state  <= IDLE;
          end
          default: begin
            busy_r <= 1'b0;
            state  <= IDLE;
          end
        endcase
      end
    end
  end

  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.p    = p_r;
endmodule

// File: tb/tb_csa_seq_mult.sv
// Directed bench for csa_seq_mult: latency, products, back-to-back, abort and reset.
module tb_csa_seq_mult;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  csa_seq_mult_if #(.WID(8))  bus8  ();
  csa_seq_mult_if #(.WID(32)) bus32 ();

  csa_seq_mult #(.WID(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8.slave));
  csa_seq_mult #(.WID(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32.slave));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pulses start for one edge; returns in cycle T+1.
  task automatic launch8(input logic [7:0] a, input logic [7:0] b);
    bus8.a = a;
    bus8.b = b;
    bus8.start = 1'b1;
    step();
    bus8.start = 1'b0;
  endtask

  // Advances until done (bounded); cyc is the cycle index relative to the start edge.
  task automatic wait_done8(input int cyc0, output int cyc, output bit busy_all, output bit timeout);
    cyc = cyc0;
    busy_all = 1'b1;
    while (bus8.done !== 1'b1 && cyc < 40) begin
      if (bus8.busy !== 1'b1) busy_all = 1'b0;
      step();
      cyc++;
    end
    timeout = (bus8.done !== 1'b1);
  endtask

  task automatic test_reset();
    bus8.start = 1'b0;  bus8.clr = 1'b0;  bus8.a = '0;  bus8.b = '0;
    bus32.start = 1'b0; bus32.clr = 1'b0; bus32.a = '0; bus32.b = '0;
    rst_n = 1'b0;
    #2;
    checks++;
    if (bus8.busy !== 1'b0 || bus8.done !== 1'b0 || bus8.p !== 16'h0000) begin
      errors++;
      $display("FAIL reset8 busy=%b done=%b p=%h want 0 0 0000", bus8.busy, bus8.done, bus8.p);
    end
    checks++;
    if (bus32.busy !== 1'b0 || bus32.done !== 1'b0 || bus32.p !== 64'h0) begin
      errors++;
      $display("FAIL reset32 busy=%b done=%b p=%h want 0 0 0", bus32.busy, bus32.done, bus32.p);
    end
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_products();
    logic [7:0]  ta [5] = '{8'h03, 8'hFF, 8'hAB, 8'h00, 8'h0F};
    logic [7:0]  tb [5] = '{8'h05, 8'hFF, 8'h00, 8'h80, 8'h0F};
    int          tc [5] = '{5, 10, 3, 10, 6};
    logic [15:0] tp [5] = '{16'h000F, 16'hFE01, 16'h0000, 16'h0000, 16'h00E1};
    int cyc;
    bit busy_all, timeout;
    for (int i = 0; i < 5; i++) begin
      launch8(ta[i], tb[i]);
      bus8.a = ~ta[i];
      bus8.b = ~tb[i];
      wait_done8(1, cyc, busy_all, timeout);
      checks++;
      if (timeout || cyc != tc[i]) begin
        errors++;
        $display("FAIL latency[%0d] done_cycle=%0d want %0d", i, cyc, tc[i]);
      end
      checks++;
      if (!busy_all) begin
        errors++;
        $display("FAIL busy_span[%0d] busy dropped before done, want high", i);
      end
      checks++;
      if (bus8.busy !== 1'b0) begin
        errors++;
        $display("FAIL busy_at_done[%0d] busy=%b want 0", i, bus8.busy);
      end
      checks++;
      if (bus8.p !== tp[i]) begin
        errors++;
        $display("FAIL product[%0d] p=%h want %h", i, bus8.p, tp[i]);
      end
      step();
      checks++;
      if (bus8.done !== 1'b0 || bus8.p !== tp[i]) begin
        errors++;
        $display("FAIL pulse_hold[%0d] done=%b p=%h want 0 %h", i, bus8.done, bus8.p, tp[i]);
      end
    end
  endtask

  task automatic test_wide32();
    logic [31:0] ta [2] = '{32'hFFFFFFFF, 32'h12345678};
    logic [31:0] tb [2] = '{32'hFFFFFFFF, 32'h00000010};
    int          tc [2] = '{34, 7};
    logic [63:0] tp [2] = '{64'hFFFFFFFE00000001, 64'h0000000123456780};
    int cyc;
    for (int i = 0; i < 2; i++) begin
      bus32.a = ta[i];
      bus32.b = tb[i];
      bus32.start = 1'b1;
      step();
      bus32.start = 1'b0;
      cyc = 1;
      while (bus32.done !== 1'b1 && cyc < 60) begin
        step();
        cyc++;
      end
      checks++;
      if (bus32.done !== 1'b1 || cyc != tc[i]) begin
        errors++;
        $display("FAIL latency32[%0d] done_cycle=%0d want %0d", i, cyc, tc[i]);
      end
      checks++;
      if (bus32.p !== tp[i]) begin
        errors++;
        $display("FAIL product32[%0d] p=%h want %h", i, bus32.p, tp[i]);
      end
      step();
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    bit busy_all, timeout;
    launch8(8'd4, 8'd5);
    wait_done8(1, cyc, busy_all, timeout);
    checks++;
    if (timeout || cyc != 5 || bus8.p !== 16'h0014) begin
      errors++;
      $display("FAIL b2b_first done_cycle=%0d p=%h want 5 0014", cyc, bus8.p);
    end
    launch8(8'd2, 8'd3);
    checks++;
    if (bus8.done !== 1'b0 || bus8.busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_accept done=%b busy=%b want 0 1", bus8.done, bus8.busy);
    end
    wait_done8(1, cyc, busy_all, timeout);
    checks++;
    if (timeout || cyc != 4 || bus8.p !== 16'h0006) begin
      errors++;
      $display("FAIL b2b_second done_cycle=%0d p=%h want 4 0006", cyc, bus8.p);
    end
    step();
  endtask

  task automatic test_start_while_busy();
    int cyc;
    int extra;
    bit busy_all, timeout;
    launch8(8'h05, 8'h81);
    bus8.a = 8'hFF;
    bus8.b = 8'hFF;
    bus8.start = 1'b1;
    step();
    bus8.start = 1'b0;
    wait_done8(2, cyc, busy_all, timeout);
    checks++;
    if (timeout || cyc != 10 || bus8.p !== 16'h0285) begin
      errors++;
      $display("FAIL busy_start done_cycle=%0d p=%h want 10 0285", cyc, bus8.p);
    end
    extra = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (bus8.done === 1'b1 || bus8.busy === 1'b1) extra++;
    end
    checks++;
    if (extra != 0) begin
      errors++;
      $display("FAIL busy_start_extra cycles_active=%0d want 0", extra);
    end
  endtask

  task automatic test_clr();
    int cyc;
    int seen;
    bit busy_all, timeout;
    launch8(8'h11, 8'hF0);
    step();
    step();
    bus8.clr = 1'b1;
    step();
    bus8.clr = 1'b0;
    checks++;
    if (bus8.busy !== 1'b0 || bus8.done !== 1'b0) begin
      errors++;
      $display("FAIL clr_abort busy=%b done=%b want 0 0", bus8.busy, bus8.done);
    end
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (bus8.done === 1'b1) seen++;
    end
    checks++;
    if (seen != 0 || bus8.p !== 16'h0285) begin
      errors++;
      $display("FAIL clr_no_done dones=%0d p=%h want 0 0285", seen, bus8.p);
    end
    bus8.a = 8'd7;
    bus8.b = 8'd9;
    bus8.start = 1'b1;
    bus8.clr = 1'b1;
    step();
    bus8.start = 1'b0;
    bus8.clr = 1'b0;
    checks++;
    if (bus8.busy !== 1'b0) begin
      errors++;
      $display("FAIL clr_idle_start busy=%b want 0", bus8.busy);
    end
    launch8(8'd7, 8'd9);
    wait_done8(1, cyc, busy_all, timeout);
    checks++;
    if (timeout || cyc != 6 || bus8.p !== 16'h003F) begin
      errors++;
      $display("FAIL clr_restart done_cycle=%0d p=%h want 6 003F", cyc, bus8.p);
    end
    step();
  endtask

  task automatic test_async_reset();
    int cyc;
    int seen;
    bit busy_all, timeout;
    launch8(8'h55, 8'hAA);
    step();
    step();
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus8.busy !== 1'b0 || bus8.done !== 1'b0 || bus8.p !== 16'h0000) begin
      errors++;
      $display("FAIL async_reset busy=%b done=%b p=%h want 0 0 0000", bus8.busy, bus8.done, bus8.p);
    end
    step();
    step();
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (bus8.done === 1'b1 || bus8.busy === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL reset_quiet active_cycles=%0d want 0", seen);
    end
    launch8(8'h0F, 8'h0F);
    wait_done8(1, cyc, busy_all, timeout);
    checks++;
    if (timeout || cyc != 6 || bus8.p !== 16'h00E1) begin
      errors++;
      $display("FAIL reset_restart done_cycle=%0d p=%h want 6 00E1", cyc, bus8.p);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_products();
    test_wide32();
    test_back_to_back();
    test_start_while_busy();
    test_clr();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
